// File: rtl/bot_wb_poller.sv
// Wishbone initiator that polls a robot responder for status, fetches bot info,
// acknowledges it, and forwards motor commands whenever they change.
module bot_wb_poller #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [15:0] POLL_INTERVAL = 16'd1000,
    parameter logic [7:0]  TIMEOUT       = 8'd255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [7:0]  mot_ctl,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rtry_i,
    output logic [31:0] bot_info,
    output logic        info_valid,
    output logic        busy,
    output logic        bus_err
);

    // state   | meaning
    // IDLE    | choose motor write or status poll
    // WAIT    | idle interval between polls
    // POLL_RD | read status (0x14)
    // INFO_RD | read bot info (0x0C)
    // ACK_SET | write 1 to 0x18
    // ACK_CLR | write 0 to 0x18
    // CTRL_WR | write motor command to 0x10
    // GAP     | one cycle with cyc low before gap_to
    typedef enum logic [2:0] {
        IDLE, WAIT, POLL_RD, INFO_RD, ACK_SET, ACK_CLR, CTRL_WR, GAP
    } state_t;

    state_t      state, state_nxt, gap_to, gap_to_nxt;
    logic [7:0]  last_ctl, ctl_data, tmo_cnt;
    logic [15:0] wait_cnt;
    logic        in_txn, abort;

    assign in_txn   = state inside {POLL_RD, INFO_RD, ACK_SET, ACK_CLR, CTRL_WR};
    assign wb_cyc_o = in_txn;
    assign wb_stb_o = in_txn;
    assign busy     = in_txn;
    assign wb_sel_o = 4'hF;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_we_o  = 1'b0;
        case (state)
            POLL_RD: wb_adr_o = BASE_ADDR | 32'h14;
            INFO_RD: wb_adr_o = BASE_ADDR | 32'h0C;
            ACK_SET: begin
                wb_adr_o = BASE_ADDR | 32'h18;
                wb_dat_o = 32'h1;
                wb_we_o  = 1'b1;
            end
            ACK_CLR: begin
                wb_adr_o = BASE_ADDR | 32'h18;
                wb_we_o  = 1'b1;
            end
            CTRL_WR: begin
                wb_adr_o = BASE_ADDR | 32'h10;
                wb_dat_o = {24'h0, ctl_data};
                wb_we_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        gap_to_nxt = gap_to;
        abort      = 1'b0;
        // a late ack on the last allowed cycle still counts as success
        if (in_txn && (wb_err_i || wb_rtry_i || (!wb_ack_i && tmo_cnt == 8'd0))) begin
            abort     = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (enable) state_nxt = (mot_ctl != last_ctl) ? CTRL_WR : POLL_RD;
                WAIT: if (!enable || wait_cnt == 16'd0) state_nxt = IDLE;
                POLL_RD: if (wb_ack_i) begin
                    if (wb_dat_i[0] && enable) begin
                        state_nxt  = GAP;
                        gap_to_nxt = INFO_RD;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
                INFO_RD: if (wb_ack_i) begin
                    state_nxt  = GAP;
                    gap_to_nxt = ACK_SET;
                end
                ACK_SET: if (wb_ack_i) begin
                    state_nxt  = GAP;
                    gap_to_nxt = ACK_CLR;
                end
                ACK_CLR: if (wb_ack_i) state_nxt = IDLE;
                CTRL_WR: if (wb_ack_i) state_nxt = IDLE;
                GAP:     state_nxt = gap_to;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            gap_to     <= IDLE;
            last_ctl   <= 8'h00;
            ctl_data   <= 8'h00;
            tmo_cnt    <= 8'd0;
            wait_cnt   <= 16'd0;
            bot_info   <= 32'h0;
            info_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_to     <= gap_to_nxt;
            info_valid <= 1'b0;
            // counters reload whenever their phase is inactive
            tmo_cnt    <= in_txn ? tmo_cnt - 8'd1 : TIMEOUT - 8'd1;
            wait_cnt   <= (state == WAIT) ? wait_cnt - 16'd1 : POLL_INTERVAL - 16'd1;
            if (state == IDLE && state_nxt == CTRL_WR) ctl_data <= mot_ctl;
            if (abort) begin
                bus_err <= 1'b1;
            end else if (wb_ack_i) begin
                if (state == INFO_RD) begin
                    bot_info   <= wb_dat_i;
                    info_valid <= 1'b1;
                end
                if (state == CTRL_WR) last_ctl <= ctl_data;
            end
        end
    end

endmodule

// File: tb/tb_bot_wb_poller.sv
// Bench for bot_wb_poller: behavioural Wishbone responder, protocol monitor and
// an in-order transaction scoreboard.
module tb_bot_wb_poller;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          P    = 20;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          t_start;
        int          t_end;
    } txn_t;

    logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0;
    logic [7:0]  mot_ctl = 8'h00;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = 32'h0, bot_info;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, info_valid, busy, bus_err;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rtry_i = 1'b0;

    int n_chk = 0, n_pass = 0, cyc_n = 0;
    int mode = 0, resp_lat = 0, lat_cnt = 0;
    int iv_cnt = 0, iv_time = 0;
    logic [31:0] iv_data = 0, status_reg = 0, info_reg = 0;
    logic [31:0] h_adr, h_dat;
    logic        h_we, prev_cyc = 0, resp_done = 0, iv_prev = 0;
    int          h_start = 0;
    txn_t        obs_q[$], exp_q[$];

    bot_wb_poller #(.BASE_ADDR(BASE), .POLL_INTERVAL(16'(P)), .TIMEOUT(8'd255)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .mot_ctl(mot_ctl),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rtry_i(wb_rtry_i),
        .bot_info(bot_info), .info_valid(info_valid), .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // responder + monitor, all on the falling edge
    always @(negedge clk) begin
        cyc_n++;
        if (resp_done) begin
            n_chk++;
            if (wb_cyc_o !== 1'b0) $display("FAIL cyc_drop: cyc=%b after response, wanted 0", wb_cyc_o);
            else n_pass++;
        end
        resp_done = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_rtry_i = 0;
        if (info_valid) begin
            iv_cnt++; iv_time = cyc_n; iv_data = bot_info;
            n_chk++;
            if (iv_prev) $display("FAIL iv_width: info_valid high 2+ cycles, wanted 1");
            else n_pass++;
        end
        iv_prev = info_valid;
        if (wb_cyc_o) begin
            n_chk++;
            if (wb_stb_o !== 1'b1 || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00 || wb_sel_o !== 4'hF)
                $display("FAIL classic: stb=%b cti=%b bte=%b sel=%h, wanted 1 000 00 f",
                         wb_stb_o, wb_cti_o, wb_bte_o, wb_sel_o);
            else n_pass++;
            if (!prev_cyc) begin
                h_adr = wb_adr_o; h_dat = wb_dat_o; h_we = wb_we_o; h_start = cyc_n; lat_cnt = 0;
            end else begin
                n_chk++;
                if (wb_adr_o !== h_adr || wb_dat_o !== h_dat || wb_we_o !== h_we)
                    $display("FAIL stable: adr=%h dat=%h we=%b, held %h %h %b",
                             wb_adr_o, wb_dat_o, wb_we_o, h_adr, h_dat, h_we);
                else n_pass++;
            end
            if (mode != 1) begin
                if (lat_cnt == resp_lat) begin
                    if (mode == 2) wb_err_i = 1;
                    else begin
                        wb_ack_i = 1;
                        if (!wb_we_o) wb_dat_i = (wb_adr_o[7:0] == 8'h14) ? status_reg :
                                                 (wb_adr_o[7:0] == 8'h0C) ? info_reg : 32'h0;
                        else if (wb_adr_o[7:0] == 8'h18 && wb_dat_o == 32'h1) status_reg = 0;
                        obs_q.push_back('{wb_we_o, wb_adr_o, wb_dat_o, h_start, cyc_n});
                    end
                    resp_done = 1;
                end
                lat_cnt++;
            end
        end
        prev_cyc = wb_cyc_o;
    end

    task automatic wait_obs(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (obs_q.size() > 0) begin ok = 1; return; end
            @(posedge clk);
        end
    endtask

    task automatic quiesce();
        int low = 0;
        enable = 0;
        for (int i = 0; i < 1000 && low < 4; i++) begin
            @(negedge clk);
            low = wb_cyc_o ? 0 : low + 1;
        end
        n_chk++;
        if (low < 4) $display("FAIL quiesce: bus never went idle");
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0; enable = 0;
        repeat (3) @(negedge clk);
        rstn = 1;
        obs_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || wb_we_o !== 0 || busy !== 0)
            $display("FAIL reset_ctl: cyc=%b stb=%b we=%b busy=%b, wanted 0", wb_cyc_o, wb_stb_o, wb_we_o, busy);
        else n_pass++;
        n_chk++;
        if (wb_adr_o !== 0 || wb_dat_o !== 0)
            $display("FAIL reset_bus: adr=%h dat=%h, wanted 0", wb_adr_o, wb_dat_o);
        else n_pass++;
        n_chk++;
        if (bot_info !== 0 || info_valid !== 0 || bus_err !== 0)
            $display("FAIL reset_info: bot_info=%h iv=%b err=%b, wanted 0", bot_info, info_valid, bus_err);
        else n_pass++;
    endtask

    task automatic test_poll_idle();
        txn_t e, o; bit ok; int ends[$], starts[$];
        status_reg = 0; enable = 1;
        repeat (2) exp_q.push_back('{1'b0, BASE | 32'h14, 32'h0, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); wait_obs(ok); n_chk++;
            if (!ok) begin $display("FAIL poll_seq: no txn, wanted adr %h", e.adr); break; end
            o = obs_q.pop_front(); starts.push_back(o.t_start); ends.push_back(o.t_end);
            if (o.we !== e.we || o.adr !== e.adr)
                $display("FAIL poll_seq: got we=%b adr=%h, wanted we=%b adr=%h", o.we, o.adr, e.we, e.adr);
            else n_pass++;
        end
        if (ends.size() == 2) begin
            n_chk++;
            if (starts[1] - ends[0] - 1 < P || starts[1] - ends[0] - 1 > P + 1)
                $display("FAIL poll_gap: %0d idle cycles, wanted %0d..%0d", starts[1] - ends[0] - 1, P, P + 1);
            else n_pass++;
        end
        quiesce();
    endtask

    task automatic test_mot_ctl();
        txn_t e, o; bit ok;
        status_reg = 0; mot_ctl = 8'hA5; enable = 1;
        exp_q.push_back('{1'b1, BASE | 32'h10, 32'h0000_00A5, 0, 0});
        repeat (2) exp_q.push_back('{1'b0, BASE | 32'h14, 32'h0, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); wait_obs(ok); n_chk++;
            if (!ok) begin $display("FAIL ctl_seq: no txn, wanted adr %h", e.adr); break; end
            o = obs_q.pop_front();
            if (o.we !== e.we || o.adr !== e.adr || (e.we && o.dat !== e.dat))
                $display("FAIL ctl_seq: got we=%b adr=%h dat=%h, wanted we=%b adr=%h dat=%h",
                         o.we, o.adr, o.dat, e.we, e.adr, e.dat);
            else n_pass++;
        end
        quiesce();
    endtask

    task automatic test_info(input logic [31:0] info, input bit change_ctl);
        txn_t e, o; bit ok; int snap, t_info, idx;
        status_reg = 1; info_reg = info; snap = iv_cnt; t_info = -100; idx = 0;
        enable = 1;
        exp_q.push_back('{1'b0, BASE | 32'h14, 32'h0, 0, 0});
        exp_q.push_back('{1'b0, BASE | 32'h0C, 32'h0, 0, 0});
        exp_q.push_back('{1'b1, BASE | 32'h18, 32'h1, 0, 0});
        exp_q.push_back('{1'b1, BASE | 32'h18, 32'h0, 0, 0});
        if (change_ctl) exp_q.push_back('{1'b1, BASE | 32'h10, 32'h0000_003C, 0, 0});
        exp_q.push_back('{1'b0, BASE | 32'h14, 32'h0, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); wait_obs(ok); n_chk++;
            if (!ok) begin $display("FAIL info_seq: no txn, wanted adr %h", e.adr); break; end
            o = obs_q.pop_front();
            if (change_ctl && idx == 0) mot_ctl = 8'h3C;
            idx++;
            if (o.adr === (BASE | 32'h0C)) t_info = o.t_end;
            if (o.we !== e.we || o.adr !== e.adr || (e.we && o.dat !== e.dat))
                $display("FAIL info_seq: got we=%b adr=%h dat=%h, wanted we=%b adr=%h dat=%h",
                         o.we, o.adr, o.dat, e.we, e.adr, e.dat);
            else n_pass++;
        end
        n_chk++;
        if (iv_cnt - snap !== 1) $display("FAIL iv_count: %0d pulses, wanted 1", iv_cnt - snap);
        else n_pass++;
        n_chk++;
        if (iv_time !== t_info + 1) $display("FAIL iv_timing: pulse at %0d, wanted %0d", iv_time, t_info + 1);
        else n_pass++;
        n_chk++;
        if (iv_data !== info || bot_info !== info)
            $display("FAIL bot_info: pulse data %h now %h, wanted %h", iv_data, bot_info, info);
        else n_pass++;
        quiesce();
    endtask

    task automatic test_ack_delay();
        txn_t o; bit ok;
        status_reg = 0; resp_lat = 3; enable = 1;
        wait_obs(ok); n_chk++;
        if (!ok) $display("FAIL delay_txn: no txn, wanted adr %h", BASE | 32'h14);
        else begin
            o = obs_q.pop_front();
            if (o.adr !== (BASE | 32'h14) || o.t_end - o.t_start !== 3)
                $display("FAIL delay_txn: adr=%h ack after %0d, wanted %h after 3", o.adr, o.t_end - o.t_start, BASE | 32'h14);
            else n_pass++;
        end
        quiesce();
        resp_lat = 0;
    endtask

    task automatic test_timeout(input logic [31:0] keep_info);
        int cnt = 0, w = 0;
        mode = 1; enable = 1;
        while (!wb_cyc_o && w < 100) begin @(negedge clk); w++; end
        while (wb_cyc_o && cnt < 400) begin cnt++; @(negedge clk); end
        n_chk++;
        if (cnt !== 255) $display("FAIL timeout_len: cyc high %0d cycles, wanted 255", cnt);
        else n_pass++;
        n_chk++;
        if (bus_err !== 1 || bot_info !== keep_info)
            $display("FAIL timeout_err: bus_err=%b bot_info=%h, wanted 1 %h", bus_err, bot_info, keep_info);
        else n_pass++;
        quiesce();
        mode = 0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (bus_err !== 1) $display("FAIL err_sticky: bus_err=%b, wanted 1", bus_err);
        else n_pass++;
    endtask

    task automatic test_wb_err();
        int w = 0;
        do_reset();
        n_chk++;
        if (bus_err !== 0) $display("FAIL err_reset: bus_err=%b, wanted 0", bus_err);
        else n_pass++;
        mode = 2; status_reg = 1; info_reg = 32'h5555_AAAA; enable = 1;
        while (!bus_err && w < 100) begin @(negedge clk); w++; end
        n_chk++;
        if (bus_err !== 1 || bot_info !== 0 || obs_q.size() != 0)
            $display("FAIL wb_err: bus_err=%b bot_info=%h acks=%0d, wanted 1 0 0", bus_err, bot_info, obs_q.size());
        else n_pass++;
        quiesce();
        mode = 0;
    endtask

    task automatic test_reset_mid();
        int w = 0, snap;
        do_reset();
        mot_ctl = 8'h00; status_reg = 1; info_reg = 32'hDEAD_BEEF; resp_lat = 6; enable = 1;
        while (!(wb_cyc_o && wb_adr_o == (BASE | 32'h0C)) && w < 200) begin @(negedge clk); w++; end
        n_chk++;
        if (w >= 200) $display("FAIL rst_mid_reach: INFO_RD never seen");
        else n_pass++;
        snap = iv_cnt;
        rstn = 0;
        @(posedge clk); #1;
        n_chk++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || wb_we_o !== 0 || busy !== 0 || wb_adr_o !== 0 || wb_dat_o !== 0)
            $display("FAIL rst_mid_bus: cyc=%b stb=%b we=%b busy=%b adr=%h dat=%h, wanted all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, busy, wb_adr_o, wb_dat_o);
        else n_pass++;
        n_chk++;
        if (bot_info !== 0 || info_valid !== 0 || bus_err !== 0)
            $display("FAIL rst_mid_info: bot_info=%h iv=%b err=%b, wanted 0", bot_info, info_valid, bus_err);
        else n_pass++;
        enable = 0;
        repeat (10) @(negedge clk);
        rstn = 1;
        repeat (5) @(negedge clk);
        n_chk++;
        if (iv_cnt !== snap) $display("FAIL rst_mid_iv: %0d pulses, wanted 0", iv_cnt - snap);
        else n_pass++;
        resp_lat = 0;
    endtask

    initial begin
        test_reset();
        test_poll_idle();
        test_mot_ctl();
        test_info(32'h1234_5678, 1'b0);
        test_info(32'hCAFE_0001, 1'b1);
        test_ack_delay();
        test_timeout(32'hCAFE_0001);
        test_wb_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
